// File: rtl/rotation_angle_gen.sv
// ============================================================================
//  rotation_angle_gen : N_AXES independent fixed-point angle generators,
//  each advanced per frame tick in HOLD / CONT / PINGPONG / ONESHOT mode.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module rotation_angle_gen #(
    parameter int          N_AXES       = 3,
    parameter int          W            = 12,
    parameter int          FRAC         = 8,
    parameter logic [W-1:0] TWO_PI       = 12'h648,
    parameter logic [W-1:0] DEFAULT_STEP = 12'h00A,
    parameter logic [W-1:0] INIT_ANGLE   = 12'h000
) (
    input  logic                                              Clk,
    input  logic                                              Reset,
    input  logic                                              frame_clk_rising_edge,
    input  logic                                              cfg_we,
    input  logic [((N_AXES > 1) ? $clog2(N_AXES) : 1)-1:0]    cfg_axis,
    input  logic [1:0]                                        cfg_mode,
    input  logic                                              cfg_dir,
    input  logic [W-1:0]                                      cfg_step,
    output logic [N_AXES*W-1:0]                               theta,
    output logic [N_AXES-1:0]                                 wrapped,
    output logic [N_AXES-1:0]                                 done
);

    localparam int AW = (N_AXES > 1) ? $clog2(N_AXES) : 1;

    localparam logic [1:0] c_MODE_HOLD     = 2'd0;
    localparam logic [1:0] c_MODE_CONT     = 2'd1;
    localparam logic [1:0] c_MODE_PINGPONG = 2'd2;
    localparam logic [1:0] c_MODE_ONESHOT  = 2'd3;

    localparam logic [0:0] c_ST_RUN  = 1'b0;
    localparam logic [0:0] c_ST_DONE = 1'b1;

    localparam logic [W-1:0] c_LIMIT    = TWO_PI - 1'b1;
    localparam logic [W:0]   c_TWO_PI_X = {1'b0, TWO_PI};
    localparam logic [W:0]   c_LIMIT_X  = {1'b0, c_LIMIT};

    if (FRAC >= W || TWO_PI == '0) begin : g_param_check
        $error("rotation_angle_gen: FRAC must be < W and TWO_PI must be non-zero");
    end

    // Step saturation is common to every axis, so it is decoded once here.
    logic [W-1:0] w_step_sat;
    assign w_step_sat = (cfg_step >= TWO_PI) ? c_LIMIT : cfg_step;

    for (genvar a = 0; a < N_AXES; a++) begin : g_axis
        logic [W-1:0] angle_q, angle_d;
        logic [W-1:0] step_q,  step_d;
        logic [1:0]   mode_q,  mode_d;
        logic         dir_q,   dir_d;
        logic [0:0]   state_q, state_d;
        logic         wrap_q,  wrap_d;

        logic         w_sel;
        logic [W:0]   w_sum;
        logic [W-1:0] w_fwd_wrap;
        logic [W-1:0] w_back_wrap;
        logic [W-1:0] w_diff;

        assign w_sel       = cfg_we && (cfg_axis == AW'(a));
        assign w_sum       = {1'b0, angle_q} + {1'b0, step_q};
        assign w_fwd_wrap  = W'(w_sum - c_TWO_PI_X);
        assign w_back_wrap = W'(({1'b0, angle_q} + c_TWO_PI_X) - {1'b0, step_q});
        assign w_diff      = angle_q - step_q;

        always_comb begin
            angle_d = angle_q;
            step_d  = step_q;
            mode_d  = mode_q;
            dir_d   = dir_q;
            state_d = state_q;
            wrap_d  = 1'b0;

            if (w_sel) begin
                mode_d  = cfg_mode;
                dir_d   = cfg_dir;
                step_d  = w_step_sat;
                state_d = c_ST_RUN;
                if (cfg_mode == c_MODE_ONESHOT) begin
                    angle_d = '0;
                end else if (angle_q > c_LIMIT) begin
                    angle_d = c_LIMIT;
                end
            // A zero step is a true no-op, so pingpong endpoints cannot fire wrapped.
            end else if (frame_clk_rising_edge && state_q == c_ST_RUN && step_q != '0) begin
                case (mode_q)
                    c_MODE_CONT: begin
                        if (!dir_q) begin
                            if (w_sum >= c_TWO_PI_X) begin
                                angle_d = w_fwd_wrap;
                                wrap_d  = 1'b1;
                            end else begin
                                angle_d = w_sum[W-1:0];
                            end
                        end else begin
                            if (angle_q >= step_q) begin
                                angle_d = w_diff;
                            end else begin
                                angle_d = w_back_wrap;
                                wrap_d  = 1'b1;
                            end
                        end
                    end
                    c_MODE_PINGPONG: begin
                        if (!dir_q) begin
                            if (w_sum >= c_LIMIT_X) begin
                                angle_d = c_LIMIT;
                                dir_d   = 1'b1;
                                wrap_d  = 1'b1;
                            end else begin
                                angle_d = w_sum[W-1:0];
                            end
                        end else begin
                            if (angle_q <= step_q) begin
                                angle_d = '0;
                                dir_d   = 1'b0;
                                wrap_d  = 1'b1;
                            end else begin
                                angle_d = w_diff;
                            end
                        end
                    end
                    c_MODE_ONESHOT: begin
                        if (w_sum >= c_TWO_PI_X) begin
                            angle_d = '0;
                            state_d = c_ST_DONE;
                        end else begin
                            angle_d = w_sum[W-1:0];
                        end
                    end
                    default: begin
                        angle_d = angle_q;
                    end
                endcase
            end
        end

        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                angle_q <= INIT_ANGLE;
                step_q  <= DEFAULT_STEP;
                mode_q  <= c_MODE_CONT;
                dir_q   <= 1'b0;
                state_q <= c_ST_RUN;
                wrap_q  <= 1'b0;
            end else begin
                angle_q <= angle_d;
                step_q  <= step_d;
                mode_q  <= mode_d;
                dir_q   <= dir_d;
                state_q <= state_d;
                wrap_q  <= wrap_d;
            end
        end

        assign theta[a*W +: W] = angle_q;
        assign wrapped[a]      = wrap_q;
        assign done[a]         = (state_q == c_ST_DONE);
    end

endmodule

`default_nettype wire

// File: tb/tb_rotation_angle_gen.sv
// ============================================================================
//  tb_rotation_angle_gen : directed vector table, randomized run against a
//  behavioural model, and an asynchronous mid-cycle reset sequence.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rotation_angle_gen;

    localparam int N  = 3;
    localparam int W  = 12;
    localparam int TP = 'h648;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          tick = 1'b0;
    logic          we = 1'b0;
    logic [1:0]    axis = '0;
    logic [1:0]    mode = '0;
    logic          dir = 1'b0;
    logic [W-1:0]  step = '0;
    logic [N*W-1:0] theta;
    logic [N-1:0]  wrapped;
    logic [N-1:0]  done;

    rotation_angle_gen dut (
        .Clk                   (Clk),
        .Reset                 (Reset),
        .frame_clk_rising_edge (tick),
        .cfg_we                (we),
        .cfg_axis              (axis),
        .cfg_mode              (mode),
        .cfg_dir               (dir),
        .cfg_step              (step),
        .theta                 (theta),
        .wrapped               (wrapped),
        .done                  (done)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    int m_ang[N], m_step[N], m_mode[N], m_dir[N], m_done[N], m_wrap[N];

    typedef struct {
        bit tk; bit w; int ax; int md; bit dr; int st;
        int e0; int e1; int e2; int ew; int ed;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int a = 0; a < N; a++) begin
            m_ang[a] = 0; m_step[a] = 'h00A; m_mode[a] = 1;
            m_dir[a] = 0; m_done[a] = 0; m_wrap[a] = 0;
        end
    endfunction

    function automatic void model_clock(bit tk, bit w, int ax, int md, bit dr, int st);
        for (int a = 0; a < N; a++) begin
            m_wrap[a] = 0;
            if (w && ax == a) begin
                m_mode[a] = md; m_dir[a] = dr; m_done[a] = 0;
                m_step[a] = (st >= TP) ? TP - 1 : st;
                if (md == 3) m_ang[a] = 0;
                else if (m_ang[a] > TP - 1) m_ang[a] = TP - 1;
            end else if (tk && !m_done[a] && m_step[a] != 0) begin
                int up;
                int dn;
                up = m_ang[a] + m_step[a];
                dn = m_ang[a] - m_step[a];
                case (m_mode[a])
                    1: if (m_dir[a] == 0) begin
                           m_wrap[a] = (up >= TP); m_ang[a] = up % TP;
                       end else begin
                           m_wrap[a] = (dn < 0); m_ang[a] = (dn + TP) % TP;
                       end
                    2: if (m_dir[a] == 0) begin
                           if (up >= TP - 1) begin
                               m_ang[a] = TP - 1; m_dir[a] = 1; m_wrap[a] = 1;
                           end else m_ang[a] = up;
                       end else begin
                           if (dn <= 0) begin
                               m_ang[a] = 0; m_dir[a] = 0; m_wrap[a] = 1;
                           end else m_ang[a] = dn;
                       end
                    3: if (up >= TP) begin
                           m_ang[a] = 0; m_done[a] = 1;
                       end else m_ang[a] = up;
                    default: ;
                endcase
            end
        end
    endfunction

    task automatic cycle(input bit tk, input bit w, input int ax, input int md,
                         input bit dr, input int st);
        tick = tk; we = w; axis = ax[1:0]; mode = md[1:0]; dir = dr; step = st[W-1:0];
        @(posedge Clk);
        model_clock(tk, w, ax, md, dr, st);
        #1;
        tick = 1'b0; we = 1'b0;
    endtask

    task automatic check_model(input string tag);
        for (int a = 0; a < N; a++) begin
            chk($sformatf("%s theta%0d", tag, a), 32'(theta[a*W +: W]), m_ang[a]);
            chk($sformatf("%s wrapped%0d", tag, a), 32'(wrapped[a]), m_wrap[a]);
            chk($sformatf("%s done%0d", tag, a), 32'(done[a]), m_done[a]);
        end
    endtask

    task automatic pulse_reset();
        @(negedge Clk);
        Reset = 1'b1;
        model_reset();
        #2;
        Reset = 1'b0;
    endtask

    task automatic add(bit tk, bit w, int ax, int md, bit dr, int st,
                       int e0, int e1, int e2, int ew, int ed);
        vt.push_back('{tk, w, ax, md, dr, st, e0, e1, e2, ew, ed});
    endtask

    initial begin
        // tick, we, axis, mode, dir, step | theta0, theta1, theta2, wrapped, done
        add(1,0,0,0,0,0,       'h00A,'h00A,'h00A,0,0);
        add(1,0,0,0,0,0,       'h014,'h014,'h014,0,0);
        add(1,0,0,0,0,0,       'h01E,'h01E,'h01E,0,0);
        add(0,1,0,3,0,'h300,   'h000,'h01E,'h01E,0,0);
        add(1,0,0,0,0,0,       'h300,'h028,'h028,0,0);
        add(1,0,0,0,0,0,       'h600,'h032,'h032,0,0);
        add(0,1,0,1,0,'h100,   'h600,'h032,'h032,0,0);
        add(0,1,1,3,0,'h008,   'h600,'h000,'h032,0,0);
        add(1,0,0,0,0,0,       'h0B8,'h008,'h03C,1,0);
        add(0,0,0,0,0,0,       'h0B8,'h008,'h03C,0,0);
        add(0,1,1,1,1,'h010,   'h0B8,'h008,'h03C,0,0);
        add(1,0,0,0,0,0,       'h1B8,'h640,'h046,2,0);
        add(0,0,0,0,0,0,       'h1B8,'h640,'h046,0,0);
        add(0,1,0,0,0,'h100,   'h1B8,'h640,'h046,0,0);
        add(0,1,1,0,0,'h010,   'h1B8,'h640,'h046,0,0);
        add(0,1,2,3,0,'h000,   'h1B8,'h640,'h000,0,0);
        add(0,1,2,2,0,'h300,   'h1B8,'h640,'h000,0,0);
        add(1,0,0,0,0,0,       'h1B8,'h640,'h300,0,0);
        add(1,0,0,0,0,0,       'h1B8,'h640,'h600,0,0);
        add(1,0,0,0,0,0,       'h1B8,'h640,'h647,4,0);
        add(1,0,0,0,0,0,       'h1B8,'h640,'h347,0,0);
        add(1,0,0,0,0,0,       'h1B8,'h640,'h047,0,0);
        add(1,0,0,0,0,0,       'h1B8,'h640,'h000,4,0);
        add(1,0,0,0,0,0,       'h1B8,'h640,'h300,0,0);
        add(0,1,2,0,0,'h300,   'h1B8,'h640,'h300,0,0);
        add(0,1,0,3,0,'h200,   'h000,'h640,'h300,0,0);
        add(1,0,0,0,0,0,       'h200,'h640,'h300,0,0);
        add(1,0,0,0,0,0,       'h400,'h640,'h300,0,0);
        add(1,0,0,0,0,0,       'h600,'h640,'h300,0,0);
        add(1,0,0,0,0,0,       'h000,'h640,'h300,0,1);
        add(1,0,0,0,0,0,       'h000,'h640,'h300,0,1);
        add(0,1,0,1,0,'h200,   'h000,'h640,'h300,0,0);
        add(1,0,0,0,0,0,       'h200,'h640,'h300,0,0);
        add(0,1,2,1,0,'h010,   'h200,'h640,'h300,0,0);
        add(1,1,1,1,0,'hFFF,   'h400,'h640,'h310,0,0);
        add(1,0,0,0,0,0,       'h600,'h63F,'h320,2,0);
        add(1,1,3,0,0,'h000,   'h1B8,'h63E,'h330,3,0);
        add(0,0,0,0,0,0,       'h1B8,'h63E,'h330,0,0);

        #2 Reset = 1'b1;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        chk("reset theta", 32'(theta), 0);
        chk("reset wrapped", 32'(wrapped), 0);
        chk("reset done", 32'(done), 0);
        Reset = 1'b0;

        foreach (vt[i]) begin
            cycle(vt[i].tk, vt[i].w, vt[i].ax, vt[i].md, vt[i].dr, vt[i].st);
            chk($sformatf("vec%0d theta0", i), 32'(theta[0 +: W]), vt[i].e0);
            chk($sformatf("vec%0d theta1", i), 32'(theta[W +: W]), vt[i].e1);
            chk($sformatf("vec%0d theta2", i), 32'(theta[2*W +: W]), vt[i].e2);
            chk($sformatf("vec%0d wrapped", i), 32'(wrapped), vt[i].ew);
            chk($sformatf("vec%0d done", i), 32'(done), vt[i].ed);
        end

        pulse_reset();
        for (int n = 0; n < 400; n++) begin
            int sel;
            int st;
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       st = int'($urandom_range(0, 'h40));
                1:       st = int'($urandom_range('h100, 'h647));
                2:       st = int'($urandom_range('h648, 'hFFF));
                default: st = int'($urandom_range(0, 'h300));
            endcase
            cycle($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1, st);
            check_model($sformatf("rnd%0d", n));
        end

        // Asynchronous reset landing between clock edges while done and wrapped are high.
        pulse_reset();
        cycle(0, 1, 0, 3, 0, 'h400);
        cycle(0, 1, 1, 1, 0, 'h640);
        cycle(1, 0, 0, 0, 0, 0);
        check_model("pre-reset a");
        cycle(1, 0, 0, 0, 0, 0);
        check_model("pre-reset b");
        #2;
        Reset = 1'b1;
        model_reset();
        #1;
        chk("async reset theta", 32'(theta), 0);
        chk("async reset wrapped", 32'(wrapped), 0);
        chk("async reset done", 32'(done), 0);
        @(negedge Clk);
        Reset = 1'b0;
        cycle(1, 0, 0, 0, 0, 0);
        check_model("post-reset 1");
        chk("post-reset theta1", 32'(theta[W +: W]), 'h00A);
        cycle(1, 0, 0, 0, 0, 0);
        check_model("post-reset 2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
